// File: rtl/gts_resp_if.sv
// Inducer/reporter handshake bundle for the genetic toggle switch responder.
// The driver (master) owns the inducers; the responder (slave) owns the reporter and status.
interface gts_resp_if;
    logic       IPTG;
    logic       aTc;
    logic       GFP;
    logic [1:0] state_o;
    logic       conflict;
    logic       last_inducer;

    modport master (
        output IPTG, aTc,
        input  GFP, state_o, conflict, last_inducer
    );

    modport slave (
        input  IPTG, aTc,
        output GFP, state_o, conflict, last_inducer
    );
endinterface

// File: rtl/gts_resp.sv
// Cycle-accurate responder model of the GTS reporter: synchronised inducers drive
// a four-state expression FSM with programmable rise/fall latencies on GFP.
module gts_resp #(
    parameter int SYNC_STAGES = 2,
    parameter int RISE_CYCLES = 8,
    parameter int FALL_CYCLES = 12,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    gts_resp_if.slave  bus
);

    typedef enum logic [1:0] {
        OFF     = 2'd0,
        RISING  = 2'd1,
        ON      = 2'd2,
        FALLING = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] RISE_LOAD = CNT_W'(RISE_CYCLES - 1);
    localparam logic [CNT_W-1:0] FALL_LOAD = CNT_W'(FALL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [SYNC_STAGES-1:0] iptg_sync;
    logic [SYNC_STAGES-1:0] atc_sync;
    logic                   iptg_s;
    logic                   atc_s;
    logic                   ind;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             gfp_q, gfp_d;
    logic             last_q, last_d;
    logic             conflict_q;

    // NOTE: every flop uses <= so all stages sample the pre-edge values together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iptg_sync <= '0;
            atc_sync  <= '0;
        end else begin
            iptg_sync <= {iptg_sync[SYNC_STAGES-2:0], bus.IPTG};
            atc_sync  <= {atc_sync[SYNC_STAGES-2:0], bus.aTc};
        end
    end

    assign iptg_s = iptg_sync[SYNC_STAGES-1];
    assign atc_s  = atc_sync[SYNC_STAGES-1];
    assign ind    = iptg_s | atc_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= OFF;
            cnt_q      <= '0;
            gfp_q      <= 1'b0;
            last_q     <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gfp_q      <= gfp_d;
            last_q     <= last_d;
            conflict_q <= iptg_s & atc_s;
        end
    end

    // The edge that enters RISING/FALLING is itself one of the latency cycles,
    // so the exit happens on the edge that sees one cycle left on the counter.
    always_comb begin
        // NOTE: hold-everything defaults first keep this block free of inferred latches.
        state_d = state_q;
        cnt_d   = cnt_q;
        gfp_d   = gfp_q;
        last_d  = last_q;
        unique case (state_q)
            OFF: begin
                if (ind) begin
                    state_d = RISING;
                    cnt_d   = RISE_LOAD;
                    last_d  = atc_s & ~iptg_s;
                end
            end
            RISING: begin
                if (!ind) begin
                    state_d = OFF;
                end else if (cnt_q <= CNT_ONE) begin
                    state_d = ON;
                    gfp_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ON: begin
                if (!ind) begin
                    state_d = FALLING;
                    cnt_d   = FALL_LOAD;
                end
            end
            FALLING: begin
                if (ind) begin
                    state_d = ON;
                end else if (cnt_q <= CNT_ONE) begin
                    state_d = OFF;
                    gfp_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: state_d = OFF;
        endcase
    end

    assign bus.GFP          = gfp_q;
    assign bus.state_o      = state_q;
    assign bus.conflict     = conflict_q;
    assign bus.last_inducer = last_q;

endmodule

// File: tb/tb_gts_resp.sv
// Bench for gts_resp: directed handshake scenarios plus a randomised driver loop,
// with a scoreboard monitor that times every GFP edge against the expected cycle.
module tb_gts_resp;

    localparam int SYNC     = 2;
    localparam int RISE     = 8;
    localparam int FALL     = 12;
    localparam int RISE_LAT = SYNC + RISE;
    localparam int FALL_LAT = SYNC + FALL;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gts_resp_if bus ();

    gts_resp #(
        .SYNC_STAGES(SYNC),
        .RISE_CYCLES(RISE),
        .FALL_CYCLES(FALL),
        .CNT_W(8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic val;
        int   cyc;
    } ev_t;

    ev_t  exp_q[$];
    ev_t  ev;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    logic prev_gfp;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every GFP edge must match the next expected event in value and cycle.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            prev_gfp = 1'b0;
        end else begin
            check("no_x", 32'($isunknown({bus.GFP, bus.state_o, bus.conflict, bus.last_inducer})), 32'd0);
            if (bus.GFP !== prev_gfp) begin
                if (exp_q.size() == 0) begin
                    check("gfp_unexpected_edge", 32'(bus.GFP), 32'(prev_gfp));
                end else begin
                    ev = exp_q.pop_front();
                    check("gfp_value", 32'(bus.GFP), 32'(ev.val));
                    check("gfp_latency", cyc, ev.cyc);
                end
                prev_gfp = bus.GFP;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic i, input logic a);
        bus.IPTG = i;
        bus.aTc  = a;
    endtask

    task automatic expect_gfp(input logic v, input int lat);
        exp_q.push_back('{v, cyc + lat});
    endtask

    task automatic wait_gfp(input logic v, input int budget);
        int n = 0;
        while (bus.GFP !== v && n < budget) begin
            step();
            n++;
        end
        check(v ? "wait_rise" : "wait_fall", 32'(bus.GFP), 32'(v));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int choice;
        drive(1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (3) step();
        check("rst_state", 32'(bus.state_o), 32'd0);
        check("rst_gfp", 32'(bus.GFP), 32'd0);
        check("rst_conflict", 32'(bus.conflict), 32'd0);
        check("rst_last", 32'(bus.last_inducer), 32'd0);
        rst_n = 1'b1;
        repeat (2) step();

        // IPTG held: rise latency and state walk 0 -> 1 -> 2.
        drive(1'b1, 1'b0);
        expect_gfp(1'b1, RISE_LAT);
        for (int k = 1; k <= RISE_LAT; k++) begin
            step();
            check("t1_state", 32'(bus.state_o), (k <= SYNC) ? 32'd0 : (k < RISE_LAT) ? 32'd1 : 32'd2);
            check("t1_gfp", 32'(bus.GFP), (k == RISE_LAT) ? 32'd1 : 32'd0);
        end
        check("t1_last", 32'(bus.last_inducer), 32'd0);

        // IPTG released: fall latency and state walk 2 -> 3 -> 0.
        drive(1'b0, 1'b0);
        expect_gfp(1'b0, FALL_LAT);
        for (int k = 1; k <= FALL_LAT; k++) begin
            step();
            check("t2_state", 32'(bus.state_o), (k <= SYNC) ? 32'd2 : (k < FALL_LAT) ? 32'd3 : 32'd0);
            check("t2_gfp", 32'(bus.GFP), (k < FALL_LAT) ? 32'd1 : 32'd0);
        end

        // Short aTc pulse: RISING then abort without any GFP pulse.
        drive(1'b0, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            step();
            check("t3_pulse_state", 32'(bus.state_o), (k <= SYNC) ? 32'd0 : 32'd1);
        end
        drive(1'b0, 1'b0);
        repeat (SYNC + 1) step();
        check("t3_abort_state", 32'(bus.state_o), 32'd0);
        repeat (15) step();
        check("t3_abort_gfp", 32'(bus.GFP), 32'd0);

        drive(1'b1, 1'b0);
        expect_gfp(1'b1, RISE_LAT);
        wait_gfp(1'b1, RISE_LAT + 5);
        check("t3_last_iptg", 32'(bus.last_inducer), 32'd0);
        drive(1'b0, 1'b0);
        expect_gfp(1'b0, FALL_LAT);
        wait_gfp(1'b0, FALL_LAT + 5);

        drive(1'b0, 1'b1);
        expect_gfp(1'b1, RISE_LAT);
        wait_gfp(1'b1, RISE_LAT + 5);
        check("t3_last_atc", 32'(bus.last_inducer), 32'd1);
        drive(1'b0, 1'b0);
        expect_gfp(1'b0, FALL_LAT);
        wait_gfp(1'b0, FALL_LAT + 5);

        // Same-cycle swap IPTG -> aTc while ON: no glitch, no conflict.
        drive(1'b1, 1'b0);
        expect_gfp(1'b1, RISE_LAT);
        wait_gfp(1'b1, RISE_LAT + 5);
        drive(1'b0, 1'b1);
        for (int k = 1; k <= 20; k++) begin
            step();
            check("t4_state", 32'(bus.state_o), 32'd2);
            check("t4_gfp", 32'(bus.GFP), 32'd1);
            check("t4_conflict", 32'(bus.conflict), 32'd0);
        end
        drive(1'b0, 1'b0);
        expect_gfp(1'b0, FALL_LAT);
        wait_gfp(1'b0, FALL_LAT + 5);
        repeat (3) step();

        // Both inducers together: conflict from edge 3, IPTG wins the tie.
        drive(1'b1, 1'b1);
        expect_gfp(1'b1, RISE_LAT);
        for (int k = 1; k <= RISE_LAT; k++) begin
            step();
            if (k == SYNC) check("t5_conflict_pre", 32'(bus.conflict), 32'd0);
            if (k == SYNC + 1) check("t5_conflict", 32'(bus.conflict), 32'd1);
        end
        check("t5_last", 32'(bus.last_inducer), 32'd0);
        check("t5_gfp", 32'(bus.GFP), 32'd1);

        // Asynchronous reset in the middle of FALLING.
        drive(1'b0, 1'b0);
        expect_gfp(1'b0, FALL_LAT);
        repeat (SYNC + 1) step();
        check("t6_falling", 32'(bus.state_o), 32'd3);
        repeat (6) step();
        #1 rst_n = 1'b0;
        #1;
        check("t6_rst_gfp", 32'(bus.GFP), 32'd0);
        check("t6_rst_state", 32'(bus.state_o), 32'd0);
        check("t6_rst_conflict", 32'(bus.conflict), 32'd0);
        #1 rst_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            check("t6_idle_state", 32'(bus.state_o), 32'd0);
        end

        // Randomised driver handshake loop.
        for (int it = 0; it < 50; it++) begin
            choice = $urandom_range(0, 2);
            repeat ($urandom_range(0, 3)) step();
            drive(choice != 1, choice != 0);
            expect_gfp(1'b1, RISE_LAT);
            wait_gfp(1'b1, RISE_LAT + 5);
            check("rnd_last", 32'(bus.last_inducer), (choice == 1) ? 32'd1 : 32'd0);
            drive(1'b0, 1'b0);
            expect_gfp(1'b0, FALL_LAT);
            wait_gfp(1'b0, FALL_LAT + 5);
        end

        repeat (5) step();
        check("sb_drain", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
